// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit operation is split into STAGES chunks of CHUNK = WIDTH/STAGES
// bits. Stage k ripples chunk k using the carry registered by stage k-1, so no
// carry path crosses a stage register. Each stage carries forward the result
// chunks already computed and the operand chunks still to be processed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   x, y       operands A and B (WIDTH bits)
//   ci         carry-in (borrow-in when sub=1)
//   sub        0 = add, 1 = subtract (B = ~y, cin = ci ^ sub)
//   in_valid   operand set valid
//   in_ready   operand set accepted when in_valid && in_ready
//   s          result (WIDTH bits), registered
//   co         carry-out of MSB (subtract: 1 = no borrow)
//   ov         two's-complement signed overflow
//   out_valid  s/co/ov valid
//   out_ready  consumer accepts the result
module pipe_rca #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_in;
    logic              c_in;
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic              can_take;
    logic              co_q, ov_q;

    always_comb begin
        b_in = sub ? ~y : y;
        c_in = ci ^ sub;
    end

    // Walk from the output back to the input: can_take is "the stage below
    // this point can accept a new entry this cycle" (empty or draining).
    always_comb begin
        adv      = '0;
        ld       = '0;
        can_take = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            adv[STAGES-1-i] = v_q[STAGES-1-i] && can_take;
            can_take        = !v_q[STAGES-1-i] || adv[STAGES-1-i];
        end
        ld[0] = in_valid && can_take;
        for (int unsigned k = 1; k < STAGES; k++) begin
            ld[k] = adv[k-1];
        end
        v_d = ld | (v_q & ~adv);
    end

    assign in_ready = can_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;       // result bits already finished below this stage
        localparam int UP = WIDTH - LO;      // operand bits still to be processed

        logic [UP-1:0]         ux, ub;
        logic                  uc;
        logic [CHUNK:0]        sum;
        logic [LO+CHUNK-1:0]   s_d, s_q;

        if (k == 0) begin : g_src
            assign ux  = x;
            assign ub  = b_in;
            assign uc  = c_in;
            assign s_d = sum[CHUNK-1:0];
        end else begin : g_src
            assign ux  = g_stage[k-1].g_fwd.x_q;
            assign ub  = g_stage[k-1].g_fwd.b_q;
            assign uc  = g_stage[k-1].g_fwd.c_q;
            assign s_d = {sum[CHUNK-1:0], g_stage[k-1].s_q};
        end

        always_comb begin
            sum = {1'b0, ux[CHUNK-1:0]} + {1'b0, ub[CHUNK-1:0]} + {{CHUNK{1'b0}}, uc};
        end

        // Data registers load only with valid data, so the last stage keeps
        // reading zero after reset until the first result arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
            end else if (ld[k]) begin
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [UP-CHUNK-1:0] x_q, b_q;
            logic                c_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (ld[k]) begin
                    x_q <= ux[UP-1:CHUNK];
                    b_q <= ub[UP-1:CHUNK];
                    c_q <= sum[CHUNK];
                end
            end
        end else begin : g_last
            // Here UP == CHUNK, so bit CHUNK-1 is the operand/result MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    co_q <= 1'b0;
                    ov_q <= 1'b0;
                end else if (ld[k]) begin
                    co_q <= sum[CHUNK];
                    ov_q <= (ux[CHUNK-1] == ub[CHUNK-1]) && (sum[CHUNK-1] != ux[CHUNK-1]);
                end
            end
        end
    end

    assign s         = g_stage[STAGES-1].s_q;
    assign co        = co_q;
    assign ov        = ov_q;
    assign out_valid = v_q[STAGES-1];

endmodule

// File: doc/pipe_rca.md
Name: pipe_rca

Overview:
Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake on both sides. It is the datapath successor to the 4-bit combinational ripple adder. The WIDTH-bit operation is split into STAGES equal chunks, and each pipeline stage ripples one chunk. Target users are the ALU/accumulator datapaths, where a long ripple chain would otherwise limit clock rate.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline stages, 1..WIDTH; CHUNK = WIDTH/STAGES bits rippled per stage

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
x  input  WIDTH  operand A
y  input  WIDTH  operand B
ci  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0 = add, 1 = subtract
in_valid  input  1  x/y/ci/sub valid this cycle
in_ready  output  1  block accepts the operand set this cycle
s  output  WIDTH  result
co  output  1  carry-out of MSB (sub: 1 = no borrow)
ov  output  1  two's-complement signed overflow
out_valid  output  1  s/co/ov valid
out_ready  input  1  consumer accepts the result this cycle

Behaviour:
- Arithmetic per operand set: B = sub ? ~y : y; cin = ci ^ sub; {co,s} = x + B + cin.
  - Result is modulo 2^WIDTH.
  - ov = (x[MSB] == B[MSB]) && (s[MSB] != x[MSB]).
  - sub=1, ci=0 gives x-y; sub=1, ci=1 gives x-y-1.
- Stage k (0..STAGES-1):
  - Ripples chunk k of x and B with the carry registered by stage k-1; stage 0 uses cin.
  - Registers the sum chunk, the carry, the lower result chunks already computed, and the upper x/B chunks still to be processed.
  - Stage STAGES-1 also registers co and ov.
  - No combinational carry crosses a stage register.
- Each stage holds a valid flag v[k].
  - adv[k] = v[k] && (k == STAGES-1 ? out_ready : (!v[k+1] || adv[k+1])).
  - Stage k loads when its upstream has data and (!v[k] || adv[k]).
- in_ready = !v[0] || adv[0]. Acceptance occurs when in_valid && in_ready.
- out_valid = v[STAGES-1]. s/co/ov come directly from the last-stage registers, with no combinational path from x/y.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
- Throughput: one result per cycle while out_ready=1.
- Backpressure:
  - When out_valid && !out_ready, the last stage holds s/co/ov stable.
  - Upstream stages keep advancing into empty slots (bubbles collapse).
  - in_ready drops only when all STAGES slots are full. Capacity is STAGES results, no loss, no duplication.
- Simultaneous accept and drain in the same cycle is legal at every stage. A full pipe with out_ready=1 keeps in_ready=1.
- Ordering: results leave in acceptance order.
- Data registers of an invalid stage are don't-care internally, but s/co/ov must read 0 whenever out_valid=0 after reset until the first result.
- Reset (rst_n low, at any time including mid-operation):
  - All v[k]=0, out_valid=0, s=0, co=0, ov=0 immediately, with no clock needed.
  - in_ready=1 from the first clock edge after deassertion.
  - In-flight operations are discarded.
- STAGES=1: degenerates to a single registered adder. Latency 1, capacity 1.
- STAGES=WIDTH: 1-bit chunks, i.e. a fully bit-pipelined ripple.

Test Plan:
- Basic add, WIDTH=16, STAGES=4:
  - x=0x0001, y=0x0002, ci=0, sub=0 accepted at cycle t.
  - Result at t+4: out_valid=1, s=0x0003, co=0, ov=0.
- Full carry ripple across all chunks:
  - x=0xFFFF, y=0x0000, ci=1 gives s=0x0000, co=1, ov=0.
  - x=0x7FFF, y=0x0001 gives s=0x8000, co=0, ov=1.
- Subtract:
  - x=0x0005, y=0x0007, sub=1, ci=0 gives s=0xFFFE, co=0, ov=0.
  - x=0x8000, y=0x0001, sub=1 gives s=0x7FFF, co=1, ov=1.
- Streaming and backpressure:
  - Send 8 back-to-back adds x=i, y=i (i=0..7) with out_ready=1, then repeat with out_ready low for 6 cycles.
  - in_ready falls after 4 accepted while blocked.
  - Outputs are 0,2,...,14 in order, none dropped or duplicated, with s held stable while stalled.
- Reset mid-flight:
  - Assert rst_n=0 asynchronously with 3 operations in flight.
  - out_valid/s/co/ov go to 0 before the next edge.
  - After release, no stale result appears, and a new add 0x1234+0x1111 yields 0x2345 after 4 cycles.
- Parameter sweep:
  - Run (WIDTH,STAGES) = (4,1), (8,2), (8,8) with random operands against the reference expression.
  - Check latency equals STAGES for each configuration.
